// File: rtl/rf_writeback_if.sv
// rf_writeback_if: issue, result and register-file-write signals of the
// RISC-16 writeback block.
//   issue_valid/issue_instr/issue_pc : instruction offered for issue
//   issue_stall                      : combinational; the offered issue is not taken
//   alu_valid/alu_result             : ALU result strobe (one pulse per result)
//   mem_valid/mem_data               : load-return strobe
//   rf_we/rf_waddr/rf_wdata          : registered register-file write port
//   busy                             : per-register pending-write scoreboard
//   proto_err                        : sticky result-strobe protocol error
// Handshake: issue is taken in any cycle where issue_valid=1 and issue_stall=0;
// result strobes carry no back-pressure and must match the queue head's kind.
interface rf_writeback_if;
  logic        issue_valid;
  logic [15:0] issue_instr;
  logic [15:0] issue_pc;
  logic        issue_stall;
  logic        alu_valid;
  logic [15:0] alu_result;
  logic        mem_valid;
  logic [15:0] mem_data;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic [7:0]  busy;
  logic        proto_err;

  modport master (
    output issue_valid, issue_instr, issue_pc, alu_valid, alu_result,
           mem_valid, mem_data,
    input  issue_stall, rf_we, rf_waddr, rf_wdata, busy, proto_err
  );

  modport slave (
    input  issue_valid, issue_instr, issue_pc, alu_valid, alu_result,
           mem_valid, mem_data,
    output issue_stall, rf_we, rf_waddr, rf_wdata, busy, proto_err
  );
endinterface

// File: rtl/rf_writeback.sv
// rf_writeback: writer side of the 8 x 16-bit RISC-16 register file.
// Keeps an in-order queue of pending register writes, completes each from the
// ALU, the load return or its stored PC+1 (JALR), and drives the single write
// port one cycle after the completing strobe.
// Ports: clk, rst_n (async active-low), bus (rf_writeback_if.slave).
module rf_writeback #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input logic          clk,
  input logic          rst_n,
  rf_writeback_if.slave bus
);

  typedef enum logic [1:0] {
    SRC_ALU = 2'd0,
    SRC_MEM = 2'd1,
    SRC_PC  = 2'd2
  } src_t;

  // Queue storage; q_vld marks live entries so busy needs no pointer math.
  logic [2:0]       q_dest [DEPTH];
  src_t             q_src  [DEPTH];
  logic [15:0]      q_pc1  [DEPTH];
  logic [DEPTH-1:0] q_vld;
  logic [PTR_W:0]   wr_ptr, rd_ptr;

  logic        rf_we_q;
  logic [2:0]  rf_waddr_q;
  logic [15:0] rf_wdata_q;
  logic        proto_err_q;

  // Instruction decode.
  logic [2:0] opcode, ra, rb, rc;
  logic       writes, chk_a, chk_b, chk_c;
  src_t       enq_src;

  assign opcode = bus.issue_instr[15:13];
  assign ra     = bus.issue_instr[12:10];
  assign rb     = bus.issue_instr[9:7];
  assign rc     = bus.issue_instr[2:0];

  logic unused_instr_bits;
  assign unused_instr_bits = ^bus.issue_instr[6:3];

  always_comb begin
    writes  = 1'b0;
    chk_a   = 1'b0;
    chk_b   = 1'b0;
    chk_c   = 1'b0;
    enq_src = SRC_ALU;
    case (opcode)
      3'b000, 3'b010: begin writes = 1'b1; chk_b = 1'b1; chk_c = 1'b1; end
      3'b001:         begin writes = 1'b1; chk_b = 1'b1; end
      3'b011:         begin writes = 1'b1; end
      3'b100, 3'b110: begin chk_a = 1'b1; chk_b = 1'b1; end
      3'b101:         begin writes = 1'b1; chk_b = 1'b1; enq_src = SRC_MEM; end
      default:        begin writes = 1'b1; chk_b = 1'b1; enq_src = SRC_PC; end
    endcase
  end

  // Scoreboard: a register stays busy through the cycle its write is on the
  // port, so a dependent reader issues only after the file has captured it.
  logic [7:0] busy_v;
  always_comb begin
    busy_v = 8'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q_vld[i]) busy_v[q_dest[i]] = 1'b1;
    end
    if (rf_we_q) busy_v[rf_waddr_q] = 1'b1;
    busy_v[0] = 1'b0;
  end

  logic empty, full, hazard, accept, enq;
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                  (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign hazard = (chk_a && busy_v[ra]) || (chk_b && busy_v[rb]) ||
                  (chk_c && busy_v[rc]);
  assign bus.issue_stall = bus.issue_valid && (full || hazard);
  assign accept = bus.issue_valid && !bus.issue_stall;
  assign enq    = accept && writes && (ra != 3'd0);

  // Head completion.
  logic [PTR_W-1:0] wr_idx, rd_idx;
  src_t             head_src;
  logic             pop, err;
  logic [15:0]      head_data;

  assign wr_idx   = wr_ptr[PTR_W-1:0];
  assign rd_idx   = rd_ptr[PTR_W-1:0];
  assign head_src = q_src[rd_idx];

  always_comb begin
    pop       = 1'b0;
    head_data = q_pc1[rd_idx];
    if (!empty) begin
      case (head_src)
        SRC_ALU: begin pop = bus.alu_valid; head_data = bus.alu_result; end
        SRC_MEM: begin pop = bus.mem_valid; head_data = bus.mem_data; end
        default: begin pop = 1'b1; end
      endcase
    end
  end

  // A mismatched strobe is flagged and otherwise ignored.
  assign err = (bus.alu_valid && (empty || head_src != SRC_ALU)) ||
               (bus.mem_valid && (empty || head_src != SRC_MEM));

  always_ff @(posedge clk) begin
    if (enq) begin
      q_dest[wr_idx] <= ra;
      q_src[wr_idx]  <= enq_src;
      q_pc1[wr_idx]  <= bus.issue_pc + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_vld       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= 3'd0;
      rf_wdata_q  <= 16'd0;
      proto_err_q <= 1'b0;
    end else begin
      // enq and pop never share an index: that would need a full queue,
      // and a full queue refuses issue.
      if (enq) begin
        q_vld[wr_idx] <= 1'b1;
        wr_ptr        <= wr_ptr + (PTR_W+1)'(1);
      end
      if (pop) begin
        q_vld[rd_idx] <= 1'b0;
        rd_ptr        <= rd_ptr + (PTR_W+1)'(1);
        rf_waddr_q    <= q_dest[rd_idx];
        rf_wdata_q    <= head_data;
      end
      rf_we_q <= pop;
      if (err) proto_err_q <= 1'b1;
    end
  end

  assign bus.rf_we     = rf_we_q;
  assign bus.rf_waddr  = rf_waddr_q;
  assign bus.rf_wdata  = rf_wdata_q;
  assign bus.busy      = busy_v;
  assign bus.proto_err = proto_err_q;

endmodule

// File: tb/tb_rf_writeback.sv
// tb_rf_writeback: directed bench for rf_writeback with hand-computed
// expectations for issue, stall, writeback, protocol error and reset.
module tb_rf_writeback;
  logic clk;
  logic rst_n;
  rf_writeback_if bus ();

  rf_writeback #(.DEPTH(4), .PTR_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; registered outputs are settled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [15:0] instr, input logic [15:0] pc);
    bus.issue_valid = 1'b1;
    bus.issue_instr = instr;
    bus.issue_pc    = pc;
    #1;
  endtask

  task automatic chk_write(input string tag, input logic [2:0] a, input logic [15:0] d);
    chk({tag, "_we"}, {15'd0, bus.rf_we}, 16'd1);
    chk({tag, "_waddr"}, {13'd0, bus.rf_waddr}, {13'd0, a});
    chk({tag, "_wdata"}, bus.rf_wdata, d);
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.issue_valid = 1'b0;
    bus.issue_instr = 16'd0;
    bus.issue_pc    = 16'd0;
    bus.alu_valid   = 1'b0;
    bus.alu_result  = 16'd0;
    bus.mem_valid   = 1'b0;
    bus.mem_data    = 16'd0;
    tick();
    tick();

    // Reset state.
    chk("rst_we", {15'd0, bus.rf_we}, 16'd0);
    chk("rst_waddr", {13'd0, bus.rf_waddr}, 16'd0);
    chk("rst_wdata", bus.rf_wdata, 16'd0);
    chk("rst_perr", {15'd0, bus.proto_err}, 16'd0);
    chk("rst_busy", {8'd0, bus.busy}, 16'd0);
    offer(16'h0881, 16'h0000);
    chk("rst_stall", {15'd0, bus.issue_stall}, 16'd0);
    bus.issue_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    // ADD r1, result two cycles later.
    offer(16'h0400, 16'h0010);
    chk("t1_stall", {15'd0, bus.issue_stall}, 16'd0);
    tick();
    bus.issue_valid = 1'b0;
    chk("t1_busy_issue", {8'd0, bus.busy}, 16'h0002);
    tick();
    chk("t1_we_early", {15'd0, bus.rf_we}, 16'd0);
    bus.alu_valid = 1'b1; bus.alu_result = 16'h1234;
    tick();
    bus.alu_valid = 1'b0;
    chk_write("t1", 3'd1, 16'h1234);
    chk("t1_busy_we", {8'd0, bus.busy}, 16'h0002);
    tick();
    chk("t1_we_drop", {15'd0, bus.rf_we}, 16'd0);
    chk("t1_busy_clr", {8'd0, bus.busy}, 16'h0000);

    // RAW: ADD r2,r1,r1 waits until the cycle after r1's write.
    offer(16'h0400, 16'h0020);
    tick();
    offer(16'h0881, 16'h0021);
    chk("t2_stall_q", {15'd0, bus.issue_stall}, 16'd1);
    tick();
    bus.alu_valid = 1'b1; bus.alu_result = 16'h00AA;
    #1;
    chk("t2_stall_strobe", {15'd0, bus.issue_stall}, 16'd1);
    tick();
    bus.alu_valid = 1'b0;
    #1;
    chk_write("t2_r1", 3'd1, 16'h00AA);
    chk("t2_stall_we", {15'd0, bus.issue_stall}, 16'd1);
    tick();
    chk("t2_stall_free", {15'd0, bus.issue_stall}, 16'd0);
    tick();
    bus.issue_valid = 1'b0;
    chk("t2_busy_r2", {8'd0, bus.busy}, 16'h0004);
    bus.alu_valid = 1'b1; bus.alu_result = 16'hBEEF;
    tick();
    bus.alu_valid = 1'b0;
    chk_write("t2_r2", 3'd2, 16'hBEEF);
    tick();

    // JALR r7 at 0xFFFF: PC+1 wraps, no strobe needed.
    offer(16'hFF80, 16'hFFFF);
    chk("t3_stall", {15'd0, bus.issue_stall}, 16'd0);
    tick();
    bus.issue_valid = 1'b0;
    chk("t3_busy", {8'd0, bus.busy}, 16'h0080);
    chk("t3_we_early", {15'd0, bus.rf_we}, 16'd0);
    tick();
    chk_write("t3", 3'd7, 16'h0000);
    tick();
    chk("t3_we_drop", {15'd0, bus.rf_we}, 16'd0);

    // Fill the queue with LW r3..r6.
    for (int i = 0; i < 4; i++) begin
      offer({3'b101, 3'(3 + i), 10'd0}, 16'(16'h0100 + i));
      tick();
    end
    bus.issue_valid = 1'b0;
    chk("t4_busy_full", {8'd0, bus.busy}, 16'h0078);
    offer(16'h0400, 16'h0200);
    chk("t4_stall_full", {15'd0, bus.issue_stall}, 16'd1);
    tick();
    chk("t4_busy_held", {8'd0, bus.busy}, 16'h0078);
    // First pop cycle: still full, still stalled.
    bus.mem_valid = 1'b1; bus.mem_data = 16'hA000;
    #1;
    chk("t4_stall_popcyc", {15'd0, bus.issue_stall}, 16'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.issue_valid = 1'b0;
      chk_write($sformatf("t4_w%0d", i), 3'(3 + i), 16'(16'hA000 + i));
      if (i < 3) bus.mem_data = 16'(16'hA001 + i);
      else bus.mem_valid = 1'b0;
    end
    tick();
    chk("t4_we_drop", {15'd0, bus.rf_we}, 16'd0);
    chk("t4_busy_clr", {8'd0, bus.busy}, 16'h0000);

    // LW r2 pending; source checks against a busy r2.
    offer(16'hA800, 16'h0300);
    tick();
    offer(16'h8800, 16'h0301);
    chk("t5_sw_ra_stall", {15'd0, bus.issue_stall}, 16'd1);
    offer(16'h0402, 16'h0301);
    chk("t5_add_rc_stall", {15'd0, bus.issue_stall}, 16'd1);
    offer(16'h2402, 16'h0301);
    chk("t5_addi_rc_ok", {15'd0, bus.issue_stall}, 16'd0);
    offer(16'h7500, 16'h0301);
    chk("t5_lui_ok", {15'd0, bus.issue_stall}, 16'd0);
    bus.issue_valid = 1'b0;
    // Wrong strobe kind.
    bus.alu_valid = 1'b1; bus.alu_result = 16'h9999;
    tick();
    bus.alu_valid = 1'b0;
    chk("t5_perr", {15'd0, bus.proto_err}, 16'd1);
    chk("t5_no_we", {15'd0, bus.rf_we}, 16'd0);
    chk("t5_busy_kept", {8'd0, bus.busy}, 16'h0004);
    tick();
    chk("t5_perr_sticky", {15'd0, bus.proto_err}, 16'd1);
    bus.mem_valid = 1'b1; bus.mem_data = 16'h5555;
    tick();
    bus.mem_valid = 1'b0;
    chk_write("t5", 3'd2, 16'h5555);
    tick();

    // ADDI r0: issues but leaves no trace.
    offer(16'h2001, 16'h0400);
    chk("t6_stall", {15'd0, bus.issue_stall}, 16'd0);
    tick();
    bus.issue_valid = 1'b0;
    chk("t6_busy", {8'd0, bus.busy}, 16'h0000);
    chk("t6_no_we", {15'd0, bus.rf_we}, 16'd0);
    tick();
    chk("t6_no_we2", {15'd0, bus.rf_we}, 16'd0);

    // Asynchronous reset with three pending loads.
    for (int i = 0; i < 3; i++) begin
      offer({3'b101, 3'(3 + i), 10'd0}, 16'(16'h0500 + i));
      tick();
    end
    bus.issue_valid = 1'b0;
    chk("t7_busy_pend", {8'd0, bus.busy}, 16'h0038);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_rst_busy", {8'd0, bus.busy}, 16'h0000);
    chk("t7_rst_perr", {15'd0, bus.proto_err}, 16'd0);
    chk("t7_rst_we", {15'd0, bus.rf_we}, 16'd0);
    chk("t7_rst_waddr", {13'd0, bus.rf_waddr}, 16'd0);
    chk("t7_rst_wdata", bus.rf_wdata, 16'd0);
    tick();
    rst_n = 1'b1;
    tick();
    offer(16'h0400, 16'h0600);
    chk("t7_stall", {15'd0, bus.issue_stall}, 16'd0);
    tick();
    bus.issue_valid = 1'b0;
    chk("t7_busy_new", {8'd0, bus.busy}, 16'h0002);
    bus.alu_valid = 1'b1; bus.alu_result = 16'h4321;
    tick();
    bus.alu_valid = 1'b0;
    chk_write("t7", 3'd1, 16'h4321);
    chk("t7_perr_clear", {15'd0, bus.proto_err}, 16'd0);
    tick();
    chk("t7_busy_end", {8'd0, bus.busy}, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/rf_writeback.md
Name: rf_writeback

Overview:
- Writer side of the 8 x 16-bit RISC-16 register file.
- Tracks every issued instruction that writes a register, in program order.
- Collects each result from the ALU, from the memory load return, or from the stored PC+1 (JALR), and drives the file's single write port.
- Publishes a per-register busy scoreboard and an issue stall for RAW hazards.

Parameters:
- DEPTH, 4, pending-write queue entries; power of two, >= 2.
- PTR_W, 2, log2(DEPTH).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- issue_valid  input  1  instruction presented for issue.
- issue_instr  input  16  instruction; opcode [15:13], rA [12:10], rB [9:7], rC [2:0].
- issue_pc  input  16  PC of the issued instruction.
- issue_stall  output  1  combinational; issue is not accepted this cycle.
- alu_valid  input  1  ALU result valid (single-cycle pulse per result).
- alu_result  input  16  ALU result.
- mem_valid  input  1  load data valid.
- mem_data  input  16  load data.
- rf_we  output  1  register file write enable (registered).
- rf_waddr  output  3  write address (registered).
- rf_wdata  output  16  write data (registered).
- busy  output  8  combinational scoreboard; bit0 is always 0.
- proto_err  output  1  sticky protocol-error flag.

Behaviour:
- Opcodes: ADD 000, ADDI 001, NAND 010, LUI 011, SW 100, LW 101, BEQ 110, JALR 111.
- Writing opcodes: ADD, ADDI, NAND, LUI, and JALR write rA. LW also writes rA.
- Source type per writing opcode: ALU for ADD/ADDI/NAND/LUI; MEM for LW; PC for JALR.
- rA == 0: no queue entry is created, no write occurs, and busy is unaffected. The instruction still issues.
- Sources checked for stall:
  - ADD/NAND: rB, rC.
  - ADDI/LW/JALR: rB.
  - LUI: none.
  - SW/BEQ: rA, rB.
- issue_stall = issue_valid & (queue full | any checked source has busy=1). Evaluated on pre-edge state; there is no bypass.
- Issue accepted = issue_valid & ~issue_stall.
  - On acceptance, a writing instruction enqueues {rA, type, issue_pc+1} at the tail. issue_pc+1 wraps modulo 2^16.
- Head completion (one pop per cycle at most):
  - ALU head: pops when alu_valid.
  - MEM head: pops when mem_valid.
  - PC head: pops in the first cycle it is head, using its stored PC+1.
- Writeback timing: on the pop edge, rf_we=1, rf_waddr=dest, and rf_wdata=selected data, for exactly one cycle. Latency is 1 cycle from the result strobe to rf_we.
- busy[r] = 1 if any valid queue entry has dest r, or if rf_we=1 with rf_waddr=r.
  - Consequence: a dependent instruction first issues in the cycle after rf_we deasserts. The file has captured the write by then.
- Simultaneous accepted issue and pop: occupancy is unchanged. A pop frees a slot only from the next cycle; full still stalls in the pop cycle.
- WAW to the same register is legal. Writes retire in order, and busy stays set until the last one has been written.
- Protocol errors:
  - Triggers: alu_valid with the queue empty or the head not ALU; mem_valid with the queue empty or the head not MEM.
  - Effect: proto_err sets and stays set until reset. The strobe is ignored and no pop occurs.
- Pointers are PTR_W+1 bits. Full = MSBs differ and low bits are equal; empty = pointers equal. Pointers wrap naturally.
- Reset (async, any time, including mid-operation):
  - Queue is emptied and pending writes are discarded.
  - Outputs: rf_we=0, rf_waddr=0, rf_wdata=0, proto_err=0, busy=0.
  - issue_stall depends on issue_valid only through the empty/not-busy state.

Test Plan:
- ADD r1 issued (instr 0x0400), alu_valid with 0x1234 two cycles later -> rf_we=1, waddr=1, wdata=0x1234 one cycle after the strobe. busy[1] is high from the issue edge until rf_we drops.
- ADD r1, then ADD r2,r1,r1 (0x0881) presented every cycle -> issue_stall=1 until the cycle after r1's rf_we, then accepted.
- JALR r7 at pc=0xFFFF (0xFF80) -> rf_we next cycle with waddr=7, wdata=0x0000 (wrap). No alu/mem strobe is needed.
- Four LW r3..r6 with no mem_valid -> fifth writing issue stalls (full).
  - Then four mem_valid pulses (0xA000..0xA003) -> four in-order writes to r3..r6 with matching data.
- LW r2 pending and alu_valid pulsed -> proto_err=1 and stays high; queue unchanged. A later mem_valid 0x5555 writes r2.
- ADDI r0 (0x2001) -> no entry, busy=0, no rf_we.
  - Variant: assert rst_n=0 mid-queue with 3 pending entries -> all outputs 0 immediately. After release, a new ADD writes correctly.
